// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM states, frame constants and parity helper.
// Used by the host-to-device transmitter and the receive path.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_DATA,
        ST_ACK,
        ST_WAIT
    } ps2_tx_state_e;

    localparam int PS2_DATA_BITS  = 8;
    // Host frame bits clocked by the device after the start bit: 8 data, parity, stop.
    localparam int PS2_HOST_BITS  = 10;
    localparam bit PS2_ODD_PARITY = 1'b1;

    function automatic logic ps2_parity(input logic [PS2_DATA_BITS-1:0] b);
        return PS2_ODD_PARITY ? ~^b : ^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a falling-edge
// detector on the synchronized clock.
module ps2_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_sync_o,
    output logic data_sync_o,
    output logic clk_fall_o
);

    logic [1:0] clk_meta_q;
    logic [1:0] data_meta_q;
    logic       clk_prev_q;

    // Idle PS/2 lines are high, so everything resets to 1 to avoid a false edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_meta_q  <= 2'b11;
            data_meta_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_meta_q  <= {clk_meta_q[0], ps2_clk_i};
            data_meta_q <= {data_meta_q[0], ps2_data_i};
            clk_prev_q  <= clk_meta_q[1];
        end
    end

    assign clk_sync_o  = clk_meta_q[1];
    assign data_sync_o = data_meta_q[1];
    assign clk_fall_o  = clk_prev_q & ~clk_meta_q[1];

endmodule

// File: rtl/axis_ps2_tx.sv
// AXI-stream to PS/2 host transmitter: accepts one command byte, inhibits the
// bus, issues a request-to-send and shifts the frame out on device clock edges.
module axis_ps2_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ       = 50000000,
    parameter int INHIBIT_US     = 100,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       axis_aclk_i,
    input  logic       axis_areset_i,
    input  logic       s_axis_tvalid_i,
    output logic       s_axis_tready_o,
    input  logic [7:0] s_axis_tdata_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o,
    output logic       tx_busy_o,
    output logic       tx_done_o,
    output logic       tx_err_o
);

    localparam int INHIBIT_CYCLES = CLK_FREQ / 1000000 * INHIBIT_US;
    localparam int CNT_MAX        = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W          = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic clk_sync;
    logic data_sync;
    logic clk_fall;

    ps2_sync_edge u_sync (
        .clk_i       (axis_aclk_i),
        .rst_i       (axis_areset_i),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .clk_sync_o  (clk_sync),
        .data_sync_o (data_sync),
        .clk_fall_o  (clk_fall)
    );

    ps2_tx_state_e              state_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [3:0]                 edge_q;
    logic [PS2_DATA_BITS-1:0]   byte_q;
    logic                       parity_q;
    logic                       clk_oe_q;
    logic                       data_oe_q;
    logic                       done_q;
    logic                       err_q;
    logic                       timeout;

    assign timeout = (cnt_q == TIMEOUT_LAST);

    always_ff @(posedge axis_aclk_i or posedge axis_areset_i) begin
        if (axis_areset_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            edge_q    <= '0;
            byte_q    <= '0;
            parity_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (s_axis_tvalid_i) begin
                        byte_q    <= s_axis_tdata_i;
                        parity_q  <= ps2_parity(s_axis_tdata_i);
                        cnt_q     <= '0;
                        clk_oe_q  <= 1'b1;
                        data_oe_q <= 1'b0;
                        state_q   <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (cnt_q == INHIBIT_LAST) begin
                        data_oe_q <= 1'b1;
                        state_q   <= ST_REQ;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_REQ: begin
                    // Release the clock with the start bit still driven low.
                    clk_oe_q <= 1'b0;
                    cnt_q    <= '0;
                    edge_q   <= '0;
                    state_q  <= ST_DATA;
                end
                ST_DATA: begin
                    if (clk_fall) begin
                        cnt_q  <= '0;
                        edge_q <= edge_q + 1'b1;
                        if (edge_q < 4'd8) begin
                            data_oe_q <= ~byte_q[edge_q[2:0]];
                        end else if (edge_q == 4'd8) begin
                            data_oe_q <= ~parity_q;
                        end else begin
                            data_oe_q <= 1'b0;
                            state_q   <= ST_ACK;
                        end
                    end else if (timeout) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ACK: begin
                    if (clk_fall) begin
                        cnt_q   <= '0;
                        done_q  <= ~data_sync;
                        err_q   <= data_sync;
                        state_q <= ST_WAIT;
                    end else if (timeout) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (clk_sync && data_sync) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (clk_fall) begin
                        cnt_q <= '0;
                    end else if (timeout) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axis_tready_o = (state_q == ST_IDLE);
    assign tx_busy_o       = (state_q != ST_IDLE);
    assign ps2_clk_oe_o    = clk_oe_q;
    assign ps2_data_oe_o   = data_oe_q;
    assign tx_done_o       = done_q;
    assign tx_err_o        = err_q;

endmodule

// File: tb/tb_axis_ps2_tx.sv
// Directed and random host-to-device PS/2 transfers against an open-drain
// device model; expectations come from the PS/2 frame rules.
module tb_axis_ps2_tx;

    localparam int CLK_FREQ   = 50000000;
    localparam int INHIBIT_US = 20;
    localparam int TIMEOUT    = 3000;
    localparam int INH_EXP    = CLK_FREQ / 1000000 * INHIBIT_US;
    localparam int HALF       = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_axis_tvalid_i = 1'b0;
    logic       s_axis_tready_o;
    logic [7:0] s_axis_tdata_i = 8'h00;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe_o;
    logic       ps2_data_oe_o;
    logic       tx_busy_o;
    logic       tx_done_o;
    logic       tx_err_o;

    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;

    assign ps2_clk_i  = dev_clk  & ~ps2_clk_oe_o;
    assign ps2_data_i = dev_data & ~ps2_data_oe_o;

    axis_ps2_tx #(
        .CLK_FREQ       (CLK_FREQ),
        .INHIBIT_US     (INHIBIT_US),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .axis_aclk_i     (clk),
        .axis_areset_i   (rst),
        .s_axis_tvalid_i (s_axis_tvalid_i),
        .s_axis_tready_o (s_axis_tready_o),
        .s_axis_tdata_i  (s_axis_tdata_i),
        .ps2_clk_i       (ps2_clk_i),
        .ps2_data_i      (ps2_data_i),
        .ps2_clk_oe_o    (ps2_clk_oe_o),
        .ps2_data_oe_o   (ps2_data_oe_o),
        .tx_busy_o       (tx_busy_o),
        .tx_done_o       (tx_done_o),
        .tx_err_o        (tx_err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (tx_done_o) done_cnt++;
        if (tx_err_o)  err_cnt++;
        if (tx_done_o && tx_err_o) both_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int guard = 0;
        while (!s_axis_tready_o && guard < 4 * TIMEOUT) begin
            @(negedge clk);
            guard++;
        end
        check(tag, int'(s_axis_tready_o), 1);
    endtask

    // mode 0: device acks, 1: device leaves data high at ack edge,
    // 2: device stops clocking after edge 4, 3: reset asserted at edge 5
    task automatic send(input logic [7:0] b, input int mode);
        int d0 = done_cnt;
        int e0 = err_cnt;
        int inh = 0;
        int req = 0;
        int guard;
        int t_fall = 0;
        logic [9:0] frame_obs = '0;
        logic [9:0] frame_exp;

        for (int i = 0; i < 8; i++) frame_exp[i] = b[i];
        frame_exp[8] = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        frame_exp[9] = 1'b1;

        wait_idle("tready_before_send");
        @(negedge clk);
        s_axis_tvalid_i = 1'b1;
        s_axis_tdata_i  = b;
        @(posedge clk);
        #1;
        // Keep offering a different byte while busy; it must be ignored.
        s_axis_tdata_i = ~b;
        @(negedge clk);
        check("tready_low_after_hs", int'(s_axis_tready_o), 0);
        check("busy_after_hs", int'(tx_busy_o), 1);

        while (ps2_clk_oe_o && !ps2_data_oe_o && inh < INH_EXP + 100) begin
            inh++;
            @(negedge clk);
        end
        s_axis_tvalid_i = 1'b0;
        while (ps2_clk_oe_o && ps2_data_oe_o && req < 10) begin
            req++;
            @(negedge clk);
        end
        check("inhibit_cycles", inh, INH_EXP);
        check("req_cycles", req, 1);
        check("start_bit_line", int'(ps2_data_i), 0);

        for (int k = 1; k <= 11; k++) begin
            if (mode == 2 && k == 5) break;
            if (k == 11 && mode != 1) dev_data = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b0;
            t_fall = cyc;
            if (mode == 3 && k == 5) begin
                repeat (4) @(negedge clk);
                rst = 1'b1;
                #1;
                check("rst_clk_oe", int'(ps2_clk_oe_o), 0);
                check("rst_data_oe", int'(ps2_data_oe_o), 0);
                check("rst_tready", int'(s_axis_tready_o), 1);
                repeat (2) @(negedge clk);
                rst = 1'b0;
                dev_clk = 1'b1;
                repeat (2) @(negedge clk);
                check("rst_no_done", done_cnt - d0, 0);
                check("rst_no_err", err_cnt - e0, 0);
                $display("xfer byte=%02h mode=reset-mid-frame", b);
                return;
            end
            repeat (HALF) @(negedge clk);
            if (k <= 10) frame_obs[k-1] = ps2_data_i;
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;

        if (mode == 2) begin
            guard = 0;
            while (err_cnt == e0 && guard < TIMEOUT + 200) begin
                @(negedge clk);
                guard++;
            end
            check("timeout_err", err_cnt - e0, 1);
            check("timeout_window", int'((cyc - t_fall) >= TIMEOUT && (cyc - t_fall) <= TIMEOUT + 8), 1);
            check("timeout_clk_oe", int'(ps2_clk_oe_o), 0);
            check("timeout_data_oe", int'(ps2_data_oe_o), 0);
            check("timeout_tready", int'(s_axis_tready_o), 1);
            check("timeout_no_done", done_cnt - d0, 0);
            $display("xfer byte=%02h mode=stall err=%0d", b, err_cnt - e0);
            return;
        end

        check("frame_bits", int'(frame_obs), int'(frame_exp));
        wait_idle("tready_after_frame");
        check("busy_after_frame", int'(tx_busy_o), 0);
        check("done_pulses", done_cnt - d0, (mode == 0) ? 1 : 0);
        check("err_pulses", err_cnt - e0, (mode == 1) ? 1 : 0);
        $display("xfer byte=%02h mode=%0d frame=%03h done=%0d err=%0d",
                 b, mode, frame_obs, done_cnt - d0, err_cnt - e0);
    endtask

    initial begin
        #2;
        check("reset_tready", int'(s_axis_tready_o), 1);
        check("reset_busy", int'(tx_busy_o), 0);
        check("reset_clk_oe", int'(ps2_clk_oe_o), 0);
        check("reset_data_oe", int'(ps2_data_oe_o), 0);
        check("reset_done", int'(tx_done_o), 0);
        check("reset_err", int'(tx_err_o), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        send(8'hED, 0);
        send(8'h01, 0);
        send(8'hFF, 0);
        send(8'h00, 0);
        send(8'h55, 1);
        send(8'hA3, 2);
        send(8'h3C, 3);
        send(8'h96, 0);
        for (int r = 0; r < 4; r++) send(8'($urandom_range(0, 255)), 0);

        check("done_err_overlap", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
